// File: rtl/uart.sv
// uart: full-duplex UART, optional-parity transmitter and receiver on one clock.
// Rx samples each bit mid-period behind a 3-FF synchroniser on serial_in.
module uart #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int PARITY_TYPE      = 0,
    parameter int CLOCKS_PER_BIT   = 8
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       enable,
    input  logic [INPUT_DATA_WIDTH-1:0]                i_data,
    output logic                                       serial_out,
    output logic                                       o_busy,
    input  logic                                       serial_in,
    output logic [INPUT_DATA_WIDTH-1:0]                received_data,
    output logic                                       data_is_valid,
    output logic                                       rx_error,
    output logic                                       baud_clk,
    output logic [INPUT_DATA_WIDTH+PARITY_ENABLED+1:0] shift_reg,
    output logic [3:0]                                 state
);

    localparam int N  = INPUT_DATA_WIDTH;
    localparam int FW = N + PARITY_ENABLED + 2;
    localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF = CW'(CLOCKS_PER_BIT / 2);
    localparam logic          PTYPE    = (PARITY_TYPE != 0);

    // ---------------- baud generator ----------------
    logic [CW-1:0] baud_cnt;

    assign baud_clk = (baud_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
        end else if (baud_clk) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CW'(1);
        end
    end

    // ---------------- transmitter ----------------
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT,
        TX_SEND
    } tx_state_t;

    tx_state_t     tx_cur;
    tx_state_t     tx_nxt;
    logic [FW-1:0] frame;
    logic [FW-1:0] sr_nxt;
    logic          so_nxt;
    logic          tx_par;

    assign tx_par = (^i_data) ^ PTYPE;

    generate
        if (PARITY_ENABLED != 0) begin : g_par
            assign frame = {1'b1, tx_par, i_data, 1'b0};
        end else begin : g_nopar
            assign frame = {1'b1, i_data, 1'b0};
        end
    endgenerate

    assign o_busy = (tx_cur != TX_IDLE);

    // The stop bit sits at the top of the frame, so shift_reg==1 means
    // the stop-bit period is the one just finishing.
    always_comb begin
        tx_nxt = tx_cur;
        sr_nxt = shift_reg;
        so_nxt = serial_out;
        unique case (tx_cur)
            TX_IDLE: begin
                if (enable) begin
                    tx_nxt = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (baud_clk) begin
                    sr_nxt = frame;
                    so_nxt = 1'b0;
                    tx_nxt = TX_SEND;
                end
            end
            TX_SEND: begin
                if (baud_clk) begin
                    if (shift_reg == FW'(1)) begin
                        sr_nxt = '0;
                        so_nxt = 1'b1;
                        tx_nxt = TX_IDLE;
                    end else begin
                        sr_nxt = shift_reg >> 1;
                        so_nxt = shift_reg[1];
                    end
                end
            end
            default: tx_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cur     <= TX_IDLE;
            shift_reg  <= '1;
            serial_out <= 1'b1;
        end else begin
            tx_cur     <= tx_nxt;
            shift_reg  <= sr_nxt;
            serial_out <= so_nxt;
        end
    end

    // ---------------- receiver ----------------
    logic sync1;
    logic sync2;
    logic rx_bit;
    logic rx_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_bit  <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= serial_in;
            sync2   <= sync1;
            rx_bit  <= sync2;
            rx_prev <= rx_bit;
        end
    end

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_phase_t;

    rx_phase_t     rx_cur;
    rx_phase_t     rx_nxt;
    logic [CW-1:0] rx_cnt;
    logic [CW-1:0] cnt_nxt;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    logic [N-1:0]  word;
    logic [N-1:0]  word_nxt;
    logic [N-1:0]  rdata_nxt;
    logic          par_bit;
    logic          par_nxt;
    logic          valid_nxt;
    logic          err_nxt;
    logic          par_ok;

    assign par_ok = (PARITY_ENABLED == 0) ||
                    (par_bit == ((^word) ^ PTYPE));

    always_comb begin
        rx_nxt    = rx_cur;
        cnt_nxt   = rx_cnt + CW'(1);
        idx_nxt   = idx;
        word_nxt  = word;
        par_nxt   = par_bit;
        rdata_nxt = received_data;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        unique case (rx_cur)
            RX_IDLE: begin
                cnt_nxt = '0;
                if (rx_prev && !rx_bit) begin
                    rx_nxt = RX_START;
                end
            end
            RX_START: begin
                // Re-check half a bit in so a short low glitch is dropped.
                if (rx_cnt == BIT_HALF) begin
                    cnt_nxt = '0;
                    idx_nxt = '0;
                    if (rx_bit) begin
                        rx_nxt = RX_IDLE;
                    end else begin
                        rx_nxt = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    cnt_nxt  = '0;
                    word_nxt = {rx_bit, word[N-1:1]};
                    idx_nxt  = idx + IW'(1);
                    if (idx == IW'(N - 1)) begin
                        if (PARITY_ENABLED != 0) begin
                            rx_nxt = RX_PARITY;
                        end else begin
                            rx_nxt = RX_STOP;
                        end
                    end
                end
            end
            RX_PARITY: begin
                if (rx_cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    par_nxt = rx_bit;
                    rx_nxt  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    rx_nxt  = RX_IDLE;
                    if (rx_bit && par_ok) begin
                        rdata_nxt = word;
                        valid_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cur        <= RX_IDLE;
            rx_cnt        <= '0;
            idx           <= '0;
            word          <= '0;
            par_bit       <= 1'b0;
            received_data <= '0;
            data_is_valid <= 1'b0;
            rx_error      <= 1'b0;
        end else begin
            rx_cur        <= rx_nxt;
            rx_cnt        <= cnt_nxt;
            idx           <= idx_nxt;
            word          <= word_nxt;
            par_bit       <= par_nxt;
            received_data <= rdata_nxt;
            data_is_valid <= valid_nxt;
            rx_error      <= err_nxt;
        end
    end

    // Debug view: DATA_BIT_k is reported as 2+k.
    always_comb begin
        state = 4'd0;
        unique case (rx_cur)
            RX_IDLE:   state = 4'd0;
            RX_START:  state = 4'd1;
            RX_DATA:   state = 4'd2 + 4'(idx);
            RX_PARITY: state = 4'(N + 2);
            RX_STOP:   state = 4'(N + 3);
            default:   state = 4'd0;
        endcase
    end

endmodule

// File: tb/tb_uart.sv
// tb_uart: directed bench for uart (loopback and externally driven Rx).
// Expected line patterns and words are hand-computed constants.
module tb_uart;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  i_data;
    logic        serial_out;
    logic        o_busy;
    logic        serial_in;
    logic [7:0]  received_data;
    logic        data_is_valid;
    logic        rx_error;
    logic        baud_clk;
    logic [10:0] shift_reg;
    logic [3:0]  state;

    logic        loop;
    logic        drv;

    int total  = 0;
    int passed = 0;

    int         valid_cnt = 0;
    int         err_cnt   = 0;
    logic [7:0] rx_log [16];

    assign serial_in = loop ? serial_out : drv;

    always #5 clk = ~clk;

    uart dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .i_data        (i_data),
        .serial_out    (serial_out),
        .o_busy        (o_busy),
        .serial_in     (serial_in),
        .received_data (received_data),
        .data_is_valid (data_is_valid),
        .rx_error      (rx_error),
        .baud_clk      (baud_clk),
        .shift_reg     (shift_reg),
        .state         (state)
    );

    always @(negedge clk) begin
        if (data_is_valid) begin
            rx_log[valid_cnt % 16] = received_data;
            valid_cnt++;
        end
        if (rx_error) begin
            err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Sends one word, samples each line bit mid-period, checks busy edges.
    task automatic tx_frame(input logic [7:0] d, output logic [10:0] line);
        i_data = d;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        check("busy_rise", o_busy, 1);
        for (int i = 0; i < 20 && serial_out !== 1'b0; i++) @(negedge clk);
        check("tx_start", serial_out, 0);
        repeat (4) @(negedge clk);
        line[0] = serial_out;
        for (int k = 1; k < 11; k++) begin
            repeat (8) @(negedge clk);
            line[k] = serial_out;
        end
        repeat (3) @(negedge clk);
        check("busy_hold", o_busy, 1);
        @(negedge clk);
        check("busy_drop", o_busy, 0);
    endtask

    task automatic drive_frame(input logic [10:0] bits);
        for (int k = 0; k < 11; k++) begin
            drv = bits[k];
            repeat (8) @(negedge clk);
        end
        drv = 1'b1;
    endtask

    initial begin
        logic [10:0] line;
        int          v0;
        int          e0;
        int          nb;

        reset  = 1'b1;
        enable = 1'b0;
        i_data = 8'h00;
        loop   = 1'b1;
        drv    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset and idle
        v0 = valid_cnt;
        e0 = err_cnt;
        repeat (50) @(negedge clk);
        check("idle_line", serial_out, 1);
        check("idle_busy", o_busy, 0);
        check("idle_sr", shift_reg, 11'h7FF);
        check("idle_state", state, 0);
        check("idle_valid", valid_cnt - v0, 0);
        check("idle_err", err_cnt - e0, 0);
        nb = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (baud_clk) nb++;
        end
        check("baud_rate", nb, 2);

        // Loopback A5
        v0 = valid_cnt;
        e0 = err_cnt;
        tx_frame(8'hA5, line);
        check("line_a5", line, 11'h54A);
        for (int i = 0; i < 200 && valid_cnt == v0; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        check("a5_valid", valid_cnt - v0, 1);
        check("a5_data", rx_log[v0 % 16], 8'hA5);
        check("a5_err", err_cnt - e0, 0);

        // Back-to-back 00 then FF
        v0 = valid_cnt;
        e0 = err_cnt;
        tx_frame(8'h00, line);
        check("line_00", line, 11'h400);
        tx_frame(8'hFF, line);
        check("line_ff", line, 11'h5FE);
        for (int i = 0; i < 200 && valid_cnt < v0 + 2; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        check("b2b_valid", valid_cnt - v0, 2);
        check("b2b_data0", rx_log[v0 % 16], 8'h00);
        check("b2b_data1", rx_log[(v0 + 1) % 16], 8'hFF);
        check("b2b_err", err_cnt - e0, 0);

        // External 3C with wrong parity
        drv  = 1'b1;
        loop = 1'b0;
        repeat (4) @(negedge clk);
        v0 = valid_cnt;
        e0 = err_cnt;
        drive_frame(11'h678);
        repeat (20) @(negedge clk);
        check("par_err", err_cnt - e0, 1);
        check("par_valid", valid_cnt - v0, 0);
        check("par_rdata", received_data, 8'hFF);
        check("par_state", state, 0);

        // External 3C with stop bit low
        v0 = valid_cnt;
        e0 = err_cnt;
        drive_frame(11'h078);
        repeat (20) @(negedge clk);
        check("stop_err", err_cnt - e0, 1);
        check("stop_valid", valid_cnt - v0, 0);
        check("stop_rdata", received_data, 8'hFF);
        check("stop_state", state, 0);

        // Two-clock low glitch
        v0 = valid_cnt;
        e0 = err_cnt;
        drv = 1'b0;
        repeat (2) @(negedge clk);
        drv = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_start", state, 1);
        repeat (10) @(negedge clk);
        check("glitch_idle", state, 0);
        repeat (100) @(negedge clk);
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_err", err_cnt - e0, 0);

        // Reset during d3, then 5A in loopback
        loop   = 1'b1;
        i_data = 8'hC3;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 20 && serial_out !== 1'b0; i++) @(negedge clk);
        check("c3_start", serial_out, 0);
        repeat (36) @(negedge clk);
        check("c3_busy", o_busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_line", serial_out, 1);
        check("rst_busy", o_busy, 0);
        check("rst_state", state, 0);
        check("rst_sr", shift_reg, 11'h7FF);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        v0 = valid_cnt;
        e0 = err_cnt;
        tx_frame(8'h5A, line);
        check("line_5a", line, 11'h4B4);
        for (int i = 0; i < 200 && valid_cnt == v0; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        check("5a_valid", valid_cnt - v0, 1);
        check("5a_data", rx_log[v0 % 16], 8'h5A);
        check("5a_rdata", received_data, 8'h5A);
        check("5a_err", err_cnt - e0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
